// File: rtl/sram_burst_reader.sv
// Two-entry-or-deeper synchronous FIFO used as the beat buffer.
// Latency: a push is visible at pop_vld the cycle after the push edge.
// Backpressure: caller must not push when full; pop only when pop_vld & pop_rdy.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;

    assign pop_vld = (count != '0);
    assign pop_dat = mem[rd_ptr];
    assign pop     = pop_vld && pop_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_vld) - CNT_W'(pop);
        end
    end
endmodule

// Burst reader: turns an (addr, len) command into SRAM reads and a valid/ready beat stream.
// Latency: first m_valid two edges after the command-accept edge, then one beat per cycle.
// Backpressure: m_ready low stalls issue once FIFO plus in-flight reads reach two.
module sram_burst_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    output logic                  rce,
    output logic                  oe,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [ADDR_WIDTH-1:0] remain_q;
    logic                  pend_q;
    logic                  pend_last_q;
    logic                  issue;
    logic                  accept;
    logic                  pop;
    logic [1:0]            fifo_cnt;
    logic [2:0]            load;
    beat_t                 cap_dat;
    beat_t                 out_dat;

    assign accept  = cmd_valid && cmd_ready;
    assign pop     = m_valid && m_ready;
    assign load    = 3'(fifo_cnt) + 3'(pend_q);
    assign cap_dat = '{last: pend_last_q, data: dout};
    assign raddr   = raddr_q;
    assign m_data  = out_dat.data;
    assign m_last  = out_dat.last;
    // A pending capture keeps the SRAM driving so dout is valid when sampled.
    assign rce     = busy || pend_q;
    assign oe      = rce;

    // A beat leaving this cycle frees its slot, which keeps the burst at one beat per cycle.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        issue     = 1'b0;
        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = !rrst;
                if (cmd_valid && !rrst) state_d = READ;
            end
            READ: begin
                issue = (load < 3'd2 + 3'(pop));
                if (issue && remain_q == '0) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && m_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q     <= IDLE;
            raddr_q     <= '0;
            remain_q    <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= issue;
            pend_last_q <= issue && (remain_q == '0);
            if (accept) begin
                raddr_q  <= cmd_addr;
                remain_q <= cmd_len;
            end else if (issue && remain_q != '0) begin
                raddr_q  <= raddr_q + ADDR_WIDTH'(1);
                remain_q <= remain_q - ADDR_WIDTH'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (2)
    ) u_beat_fifo (
        .clk      (rclk),
        .rst      (rrst),
        .push_vld (pend_q),
        .push_dat (cap_dat),
        .pop_rdy  (m_ready),
        .pop_vld  (m_valid),
        .pop_dat  (out_dat),
        .count    (fifo_cnt)
    );
endmodule

// File: tb/tb_sram_burst_reader.sv
// Bench for sram_burst_reader: SRAM model, beat scoreboard built from (addr, len) commands.
module tb_sram_burst_reader;
    localparam int AW   = 5;
    localparam int DW   = 16;
    localparam int MEMN = 1 << AW;

    logic          rclk = 1'b0;
    logic          rrst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          rce, oe;
    logic [AW-1:0] raddr;
    logic [DW-1:0] dout = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;

    always #5 rclk = ~rclk;

    sram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .rce       (rce),
        .oe        (oe),
        .raddr     (raddr),
        .dout      (dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy)
    );

    // Registered-read SRAM.
    logic [DW-1:0] mem [MEMN];
    always @(posedge rclk) dout <= (rce && oe) ? mem[raddr] : 'x;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    logic [AW-1:0] raddr_log[$];
    int            rdy_mode = 0;
    int            cyc = 0;
    int            acc_cyc = 0;
    int            beat_cnt = 0;
    bit            first_pend = 0;
    bit            prev_stall = 0;
    bit            prev_lasths = 0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    // Sink readiness: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
    always @(negedge rclk) begin
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor samples after the drivers have settled, away from the rising edge.
    always @(negedge rclk) begin
        #1;
        cyc++;
        if (rrst) begin
            chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
            exp_q.delete();
            first_pend  = 0;
            prev_stall  = 0;
            prev_lasths = 0;
        end else begin
            if (prev_lasths) begin
                chk("busy_after_last", 32'(busy), 32'd0);
                chk("ready_after_last", 32'(cmd_ready), 32'd1);
            end
            chk("cmd_ready_vs_busy", 32'(cmd_ready), 32'(!busy));
            if (busy) chk("rce_oe_busy", 32'({rce, oe}), 32'd3);
            if (rce && (raddr_log.size() == 0 || raddr_log[$] != raddr))
                raddr_log.push_back(raddr);
            if (prev_stall) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'(m_data), 32'(prev_data));
                chk("stall_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && first_pend) begin
                first_pend = 0;
                // Accept edge follows sample acc_cyc; two edges later is sample acc_cyc+3.
                if (rdy_mode == 0) chk("first_latency", 32'(cyc - acc_cyc), 32'd3);
            end else if (rdy_mode == 0 && !first_pend && exp_q.size() != 0) begin
                chk("sustain", 32'(m_valid), 32'd1);
            end
            if (cmd_valid && cmd_ready) begin
                chk("accept_q_empty", 32'(exp_q.size()), 32'd0);
                for (int i = 0; i <= int'(cmd_len); i++) begin
                    e.data = mem[(int'(cmd_addr) + i) % MEMN];
                    e.last = (i == int'(cmd_len));
                    exp_q.push_back(e);
                end
                acc_cyc    = cyc;
                first_pend = 1;
            end
            prev_lasths = 0;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(m_data), 32'(e.data));
                    chk("beat_last", 32'(m_last), 32'(e.last));
                end
                beat_cnt++;
                prev_lasths = m_last;
                if (m_last) chk("last_hs_cmd_ready", 32'(cmd_ready), 32'd0);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic send_cmd(input int a, input int l);
        bit done = 0;
        @(negedge rclk);
        cmd_valid = 1'b1;
        cmd_addr  = AW'(a);
        cmd_len   = AW'(l);
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (cmd_ready) done = 1;
            @(negedge rclk);
        end
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_len   = AW'($urandom);
        if (!done) chk("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge rclk);
            #2;
            if (!busy && exp_q.size() == 0) ok = 1;
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_raddr(input int a, input int l);
        chk("raddr_count", 32'(raddr_log.size()), 32'(l + 1));
        for (int i = 0; i <= l && i < raddr_log.size(); i++)
            chk("raddr_seq", 32'(raddr_log[i]), 32'((a + i) % MEMN));
    endtask

    task automatic burst(input int a, input int l);
        raddr_log.delete();
        send_cmd(a, l);
        wait_idle(600);
        check_raddr(a, l);
    endtask

    task automatic check_reset_outputs();
        chk("rst_rce", 32'(rce), 32'd0);
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_release_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEMN; i++) mem[i] = DW'(i + 'h100);
        repeat (3) @(negedge rclk);
        rrst = 1'b0;
        #2;
        check_reset_outputs();

        rdy_mode = 0;
        burst(3, 3);
        burst(30, 3);

        rdy_mode = 1;
        burst(0, 7);

        rdy_mode = 0;
        burst(5, 0);

        // Reset in the middle of a full-memory burst.
        raddr_log.delete();
        beat_cnt = 0;
        send_cmd(0, 31);
        for (int k = 0; k < 200 && beat_cnt < 10; k++) @(negedge rclk);
        chk("beats_before_reset", 32'(beat_cnt >= 10), 32'd1);
        @(negedge rclk);
        rrst = 1'b1;
        @(negedge rclk);
        rrst = 1'b0;
        #2;
        check_reset_outputs();
        beat_cnt = 0;
        repeat (6) @(negedge rclk);
        chk("no_beats_after_reset", 32'(beat_cnt), 32'd0);
        burst(2, 1);

        // Uninterrupted full-memory burst with wrap.
        burst(17, 31);

        rdy_mode = 2;
        for (int i = 0; i < MEMN; i++) mem[i] = DW'($urandom);
        for (int n = 0; n < 14; n++) begin
            int a, l;
            a = $urandom_range(0, MEMN - 1);
            l = (n == 6) ? MEMN - 1 : $urandom_range(0, 9);
            burst(a, l);
            repeat ($urandom_range(0, 2)) @(negedge rclk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
